// File: rtl/ram_bus_arbiter_pkg.sv
// Shared encodings for the serial RAM bus arbiter: bus_mode values and FSM states.
package ram_bus_arbiter_pkg;

    localparam logic BUS_MODE_MCU = 1'b0;
    localparam logic BUS_MODE_COP = 1'b1;

    localparam int ARB_STATE_WIDTH = 2;

    typedef enum logic [ARB_STATE_WIDTH-1:0] {
        ARB_STATE_IDLE    = 2'd0,
        ARB_STATE_GUARD   = 2'd1,
        ARB_STATE_OWN     = 2'd2,
        ARB_STATE_RELEASE = 2'd3
    } arb_state_t;

    // Round-robin pick when both sides ask at once: whoever did not own last wins.
    function automatic logic pick_target(input logic mcu_req, input logic cop_req,
                                         input logic last_owner);
        if (mcu_req && cop_req) begin
            return ~last_owner;
        end
        return cop_req ? BUS_MODE_COP : BUS_MODE_MCU;
    endfunction

endpackage

// File: rtl/ram_bus_arbiter_signal_sync.sv
// Multi-flop 1-bit synchronizer with an asynchronous reset to a chosen idle level.
module signal_sync #(
    parameter int   STAGES    = 2,
    parameter logic RESET_VAL = 1'b0
) (
    input  logic i_clk,
    input  logic i_reset,
    input  logic i_async,
    output logic o_sync
);

    logic [STAGES-1:0] r_stages;

    generate
        for (genvar gi = 0; gi < STAGES; gi++) begin : g_stage
            // One flop of the chain; stage 0 samples the raw async input.
            always_ff @(posedge i_clk or posedge i_reset) begin
                if (i_reset) begin
                    r_stages[gi] <= RESET_VAL;
                end else if (gi == 0) begin
                    r_stages[gi] <= i_async;
                end else begin
                    r_stages[gi] <= r_stages[(gi == 0) ? 0 : gi-1];
                end
            end
        end
    endgenerate

    assign o_sync = r_stages[STAGES-1];

endmodule

// File: rtl/ram_bus_arbiter.sv
// Grants the shared serial RAM SPI bus to the MCU or the coprocessor, one at a time,
// switching bus_mode only while no grant is held and settling it for a guard gap first.
module ram_bus_arbiter
    import ram_bus_arbiter_pkg::*;
#(
    parameter int SYNC_STAGES  = 2,
    parameter int GUARD_CYCLES = 4,
    parameter int HOLD_LIMIT   = 1024
) (
    input  logic i_clk,
    input  logic i_reset,
    input  logic i_mcu_req,
    input  logic i_cop_req,
    input  logic i_mcu_nss,
    input  logic i_cop_nss,
    input  logic i_preempt_clr,
    output logic o_bus_mode,
    output logic o_mcu_grant,
    output logic o_cop_grant,
    output logic o_ram_busy,
    output logic o_preempted
);

    localparam int GW = $clog2(GUARD_CYCLES + 1);
    localparam int HW = $clog2(HOLD_LIMIT + 1);
    localparam logic [GW-1:0] GUARD_LAST = GW'(GUARD_CYCLES - 1);
    localparam logic [HW-1:0] HOLD_MAX   = HW'(HOLD_LIMIT);

    logic w_mcu_req, w_cop_req, w_mcu_nss, w_cop_nss;

    signal_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_mcu_req (
        .i_clk(i_clk), .i_reset(i_reset), .i_async(i_mcu_req), .o_sync(w_mcu_req));
    signal_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_cop_req (
        .i_clk(i_clk), .i_reset(i_reset), .i_async(i_cop_req), .o_sync(w_cop_req));
    signal_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_mcu_nss (
        .i_clk(i_clk), .i_reset(i_reset), .i_async(i_mcu_nss), .o_sync(w_mcu_nss));
    signal_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_cop_nss (
        .i_clk(i_clk), .i_reset(i_reset), .i_async(i_cop_nss), .o_sync(w_cop_nss));

    arb_state_t    r_state, r_state_next;
    logic          r_bus_mode, r_bus_mode_next;
    logic          r_mcu_grant, r_mcu_grant_next;
    logic          r_cop_grant, r_cop_grant_next;
    logic          r_ram_busy, r_ram_busy_next;
    logic          r_preempted, r_preempted_next;
    logic          r_last_owner, r_last_owner_next;
    logic [GW-1:0] r_guard_cnt, r_guard_cnt_next;
    logic [HW-1:0] r_hold_cnt, r_hold_cnt_next;

    // bus_mode doubles as the owner identity from GUARD through RELEASE.
    logic w_owner_req, w_owner_nss, w_other_req;
    assign w_owner_req = (r_bus_mode == BUS_MODE_COP) ? w_cop_req : w_mcu_req;
    assign w_owner_nss = (r_bus_mode == BUS_MODE_COP) ? w_cop_nss : w_mcu_nss;
    assign w_other_req = (r_bus_mode == BUS_MODE_COP) ? w_mcu_req : w_cop_req;

    // State and registered outputs; reset drops grants at once, last owner starts as COP.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state      <= ARB_STATE_IDLE;
            r_bus_mode   <= BUS_MODE_MCU;
            r_mcu_grant  <= 1'b0;
            r_cop_grant  <= 1'b0;
            r_ram_busy   <= 1'b0;
            r_preempted  <= 1'b0;
            r_last_owner <= BUS_MODE_COP;
            r_guard_cnt  <= '0;
            r_hold_cnt   <= '0;
        end else begin
            r_state      <= r_state_next;
            r_bus_mode   <= r_bus_mode_next;
            r_mcu_grant  <= r_mcu_grant_next;
            r_cop_grant  <= r_cop_grant_next;
            r_ram_busy   <= r_ram_busy_next;
            r_preempted  <= r_preempted_next;
            r_last_owner <= r_last_owner_next;
            r_guard_cnt  <= r_guard_cnt_next;
            r_hold_cnt   <= r_hold_cnt_next;
        end
    end

    // Next-state logic: pick target, guard gap, ownership with preemption, one-clk release.
    always_comb begin
        r_state_next      = r_state;
        r_bus_mode_next   = r_bus_mode;
        r_mcu_grant_next  = r_mcu_grant;
        r_cop_grant_next  = r_cop_grant;
        r_preempted_next  = r_preempted;
        r_last_owner_next = r_last_owner;
        r_guard_cnt_next  = r_guard_cnt;
        r_hold_cnt_next   = r_hold_cnt;

        // A preempt in the same clk overrides the clear below.
        if (i_preempt_clr) begin
            r_preempted_next = 1'b0;
        end

        case (r_state)
            ARB_STATE_IDLE: begin
                r_mcu_grant_next = 1'b0;
                r_cop_grant_next = 1'b0;
                if (w_mcu_req || w_cop_req) begin
                    r_bus_mode_next  = pick_target(w_mcu_req, w_cop_req, r_last_owner);
                    r_guard_cnt_next = '0;
                    r_state_next     = ARB_STATE_GUARD;
                end
            end
            ARB_STATE_GUARD: begin
                if (r_guard_cnt == GUARD_LAST) begin
                    r_mcu_grant_next = (r_bus_mode == BUS_MODE_MCU);
                    r_cop_grant_next = (r_bus_mode == BUS_MODE_COP);
                    r_hold_cnt_next  = '0;
                    r_state_next     = ARB_STATE_OWN;
                end else begin
                    r_guard_cnt_next = r_guard_cnt + GW'(1);
                end
            end
            ARB_STATE_OWN: begin
                if (!w_owner_req && w_owner_nss) begin
                    r_mcu_grant_next = 1'b0;
                    r_cop_grant_next = 1'b0;
                    r_state_next     = ARB_STATE_RELEASE;
                end else if (w_owner_nss && (r_hold_cnt == HOLD_MAX)) begin
                    r_mcu_grant_next = 1'b0;
                    r_cop_grant_next = 1'b0;
                    r_preempted_next = 1'b1;
                    r_state_next     = ARB_STATE_RELEASE;
                end else if (w_owner_nss && w_other_req) begin
                    if (r_hold_cnt != HOLD_MAX) begin
                        r_hold_cnt_next = r_hold_cnt + HW'(1);
                    end
                end else begin
                    r_hold_cnt_next = '0;
                end
            end
            default: begin
                r_mcu_grant_next  = 1'b0;
                r_cop_grant_next  = 1'b0;
                r_last_owner_next = r_bus_mode;
                r_hold_cnt_next   = '0;
                r_state_next      = ARB_STATE_IDLE;
            end
        endcase

        r_ram_busy_next = (r_state_next != ARB_STATE_IDLE);
    end

    assign o_bus_mode  = r_bus_mode;
    assign o_mcu_grant = r_mcu_grant;
    assign o_cop_grant = r_cop_grant;
    assign o_ram_busy  = r_ram_busy;
    assign o_preempted = r_preempted;

endmodule

// File: tb/tb_ram_bus_arbiter.sv
// Directed and random checks of the RAM bus arbiter with a short hold limit.
module tb_ram_bus_arbiter;

    logic clk = 1'b0;
    logic reset, mcu_req, cop_req, mcu_nss, cop_nss, preempt_clr;
    logic bus_mode, mcu_grant, cop_grant, ram_busy, preempted;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    ram_bus_arbiter #(.SYNC_STAGES(2), .GUARD_CYCLES(4), .HOLD_LIMIT(16)) dut (
        .i_clk(clk), .i_reset(reset),
        .i_mcu_req(mcu_req), .i_cop_req(cop_req),
        .i_mcu_nss(mcu_nss), .i_cop_nss(cop_nss),
        .i_preempt_clr(preempt_clr),
        .o_bus_mode(bus_mode), .o_mcu_grant(mcu_grant), .o_cop_grant(cop_grant),
        .o_ram_busy(ram_busy), .o_preempted(preempted));

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1; mcu_req = 1'b0; cop_req = 1'b0;
        mcu_nss = 1'b1; cop_nss = 1'b1; preempt_clr = 1'b0;
        step(); step();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        n_checks++;
        if ({bus_mode, mcu_grant, cop_grant, ram_busy, preempted} !== 5'b00000)
            $display("FAIL reset_outputs got=%b want=00000",
                     {bus_mode, mcu_grant, cop_grant, ram_busy, preempted});
        else n_pass++;
        $display("test_reset done");
    endtask

    // mcu_req alone: grant exactly 7 clks after the first sampling edge, bus_mode 0.
    task automatic test_mcu_latency();
        do_reset();
        mcu_req = 1'b1;
        for (int e = 1; e <= 7; e++) begin
            step();
            n_checks++;
            if (mcu_grant !== (e == 7) || bus_mode !== 1'b0 || cop_grant !== 1'b0)
                $display("FAIL latency edge=%0d got grant=%b mode=%b want grant=%b mode=0",
                         e, mcu_grant, bus_mode, (e == 7));
            else n_pass++;
        end
        mcu_req = 1'b0;
        $display("test_mcu_latency done");
    endtask

    // Simultaneous requests: MCU first, then COP after release + idle + guard.
    task automatic test_tie_handover();
        do_reset();
        mcu_req = 1'b1; cop_req = 1'b1;
        repeat (7) step();
        n_checks++;
        if (mcu_grant !== 1'b1 || cop_grant !== 1'b0 || bus_mode !== 1'b0)
            $display("FAIL tie_first got m=%b c=%b mode=%b want m=1 c=0 mode=0",
                     mcu_grant, cop_grant, bus_mode);
        else n_pass++;
        mcu_req = 1'b0;
        for (int e = 1; e <= 9; e++) begin
            step();
            n_checks++;
            if (mcu_grant !== (e < 3) || cop_grant !== (e >= 9) ||
                bus_mode !== (e >= 5) || ram_busy !== (e != 4))
                $display("FAIL handover edge=%0d got m=%b c=%b mode=%b busy=%b want m=%b c=%b mode=%b busy=%b",
                         e, mcu_grant, cop_grant, bus_mode, ram_busy,
                         (e < 3), (e >= 9), (e >= 5), (e != 4));
            else n_pass++;
        end
        cop_req = 1'b0;
        $display("test_tie_handover done");
    endtask

    // Owner keeps the bus while its chip-select is low even after dropping req.
    task automatic test_nss_hold();
        do_reset();
        mcu_req = 1'b1;
        repeat (7) step();
        mcu_nss = 1'b0;
        repeat (3) step();
        mcu_req = 1'b0;
        for (int e = 1; e <= 10; e++) begin
            step();
            n_checks++;
            if (mcu_grant !== 1'b1)
                $display("FAIL nss_hold edge=%0d got grant=%b want 1", e, mcu_grant);
            else n_pass++;
        end
        mcu_nss = 1'b1;
        for (int e = 1; e <= 4; e++) begin
            step();
            n_checks++;
            if (mcu_grant !== (e < 3) || ram_busy !== (e < 4))
                $display("FAIL nss_release edge=%0d got grant=%b busy=%b want grant=%b busy=%b",
                         e, mcu_grant, ram_busy, (e < 3), (e < 4));
            else n_pass++;
        end
        $display("test_nss_hold done");
    endtask

    // Idle COP owner with MCU waiting is preempted after the hold limit.
    task automatic test_preempt();
        int e;
        do_reset();
        cop_req = 1'b1;
        repeat (7) step();
        n_checks++;
        if (cop_grant !== 1'b1 || bus_mode !== 1'b1)
            $display("FAIL preempt_setup got c=%b mode=%b want c=1 mode=1", cop_grant, bus_mode);
        else n_pass++;
        mcu_req = 1'b1;
        e = 0;
        while (preempted !== 1'b1 && e < 40) begin
            step(); e++;
        end
        n_checks++;
        if (e != 19 || cop_grant !== 1'b0)
            $display("FAIL preempt_time got edge=%0d c=%b want edge=19 c=0", e, cop_grant);
        else n_pass++;
        while (mcu_grant !== 1'b1 && e < 60) begin
            step(); e++;
        end
        n_checks++;
        if (e != 25 || bus_mode !== 1'b0 || preempted !== 1'b1)
            $display("FAIL preempt_handover got edge=%0d mode=%b pre=%b want edge=25 mode=0 pre=1",
                     e, bus_mode, preempted);
        else n_pass++;
        preempt_clr = 1'b1;
        step();
        preempt_clr = 1'b0;
        n_checks++;
        if (preempted !== 1'b0 || mcu_grant !== 1'b1)
            $display("FAIL preempt_clr got pre=%b m=%b want pre=0 m=1", preempted, mcu_grant);
        else n_pass++;
        cop_req = 1'b0; mcu_req = 1'b0;
        $display("test_preempt done");
    endtask

    // Async reset in OWN clears grants and bus_mode without waiting for a clock.
    task automatic test_reset_mid_own();
        do_reset();
        cop_req = 1'b1;
        repeat (7) step();
        #2;
        reset = 1'b1;
        #1;
        n_checks++;
        if ({bus_mode, mcu_grant, cop_grant, ram_busy} !== 4'b0000)
            $display("FAIL reset_mid_own got=%b want=0000",
                     {bus_mode, mcu_grant, cop_grant, ram_busy});
        else n_pass++;
        cop_req = 1'b0;
        step();
        reset = 1'b0;
        $display("test_reset_mid_own done");
    endtask

    // Random traffic: exclusive grants, grant matches bus_mode, mode moves only with no grant.
    task automatic test_stress();
        logic prev_mode, prev_any;
        do_reset();
        prev_mode = bus_mode;
        prev_any  = 1'b0;
        for (int c = 0; c < 600; c++) begin
            if ($urandom_range(0, 7) == 0) mcu_req = ~mcu_req;
            if ($urandom_range(0, 7) == 0) cop_req = ~cop_req;
            if ($urandom_range(0, 3) == 0) mcu_nss = ~mcu_nss;
            if ($urandom_range(0, 3) == 0) cop_nss = ~cop_nss;
            step();
            n_checks++;
            if ((mcu_grant && cop_grant) ||
                (mcu_grant && bus_mode !== 1'b0) || (cop_grant && bus_mode !== 1'b1) ||
                ((bus_mode !== prev_mode) && (prev_any || mcu_grant || cop_grant)))
                $display("FAIL stress cyc=%0d got m=%b c=%b mode=%b prev_mode=%b prev_any=%b want exclusive grant matching a stable mode",
                         c, mcu_grant, cop_grant, bus_mode, prev_mode, prev_any);
            else n_pass++;
            prev_mode = bus_mode;
            prev_any  = mcu_grant | cop_grant;
        end
        $display("test_stress done");
    endtask

    initial begin
        test_reset();
        test_mcu_latency();
        test_tie_handover();
        test_nss_hold();
        test_preempt();
        test_reset_mid_own();
        test_stress();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
